// File: rtl/data_mem_pkg.sv
// Shared encodings for the memory-stage data memory: access sizes, FSM states
// and the byte-lane decode used by both the store path and the load aligner.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } stateT;

    // Byte lanes touched by an access; illegal sizes touch nothing.
    function automatic logic [3:0] laneMask(input logic [1:0] addrLo, input logic [1:0] size);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SZ_BYTE: mask = 4'b0001 << addrLo;
            SZ_HALF: mask = addrLo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/data_mem_load_align.sv
// Right-justifies the addressed byte/half/word of a raw memory word and
// sign- or zero-extends it to 32 bits.
module load_align
    import data_mem_pkg::*;
(
    input  logic [31:0] rawWord,
    input  logic [1:0]  addrLo,
    input  logic [1:0]  size,
    input  logic        signedLd,
    output logic [31:0] loadVal
);

    logic [31:0] byteShifted;
    logic [31:0] halfShifted;

    // Halves sit on lane pairs, so only addr[1] selects them.
    assign byteShifted = rawWord >> {addrLo, 3'b000};
    assign halfShifted = rawWord >> {addrLo[1], 4'b0000};

    always_comb begin
        loadVal = 32'h0;
        case (size)
            SZ_BYTE: loadVal = {{24{signedLd & byteShifted[7]}}, byteShifted[7:0]};
            SZ_HALF: loadVal = {{16{signedLd & halfShifted[15]}}, halfShifted[15:0]};
            SZ_WORD: loadVal = rawWord;
            default: loadVal = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory with registered load data, legality
// flags, and a post-reset clearing sequence before requests are accepted.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [1:0]        size,
    input  logic              signedLd,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    output logic              misalign,
    output logic              outOfRange,
    output logic              ready
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    stateT             stateReg;
    logic [IDX_W-1:0]  clearCntReg;
    logic              readyReg;
    logic [31:0]       rdDataReg;
    logic              rdValidReg;
    logic              misalignReg;
    logic              outOfRangeReg;

    logic [IDX_W-1:0]  wordIdx;
    logic              inRange;
    logic              isMisaligned;
    logic              isLegal;
    logic              doStore;
    logic              inInit;
    logic [3:0]        storeMask;
    logic [31:0]       storeData;
    logic [31:0]       rawWord;
    logic [31:0]       loadVal;

    assign wordIdx      = addr[IDX_W+1:2];
    assign inRange      = addr[31:2] < 30'(DEPTH_WORDS);
    assign isMisaligned = (size == 2'b11)
                        | ((size == SZ_HALF) & addr[0])
                        | ((size == SZ_WORD) & (addr[1:0] != 2'b00));
    assign isLegal      = ~isMisaligned & inRange;
    assign inInit       = rst_n & (stateReg == ST_INIT);
    assign doStore      = rst_n & (stateReg == ST_READY) & memWrite & isLegal;
    assign storeMask    = laneMask(addr[1:0], size);

    // Replicate the store operand across lanes; the mask picks the live ones.
    always_comb begin
        storeData = wrData;
        case (size)
            SZ_BYTE: storeData = {4{wrData[7:0]}};
            SZ_HALF: storeData = {2{wrData[15:0]}};
            default: storeData = wrData;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            logic [7:0]       laneMem [DEPTH_WORDS];
            logic             laneWe;
            logic [IDX_W-1:0] laneAddr;
            logic [7:0]       laneWr;

            assign laneWe   = inInit | (doStore & storeMask[gi]);
            assign laneAddr = inInit ? clearCntReg : wordIdx;
            assign laneWr   = inInit ? 8'h00 : storeData[gi*8 +: 8];

            always_ff @(posedge clk) begin
                if (laneWe) begin
                    laneMem[laneAddr] <= laneWr;
                end
            end

            assign rawWord[gi*8 +: 8] = laneMem[wordIdx];
        end
    endgenerate

    load_align uLoadAlign (
        .rawWord (rawWord),
        .addrLo  (addr[1:0]),
        .size    (size),
        .signedLd(signedLd),
        .loadVal (loadVal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg      <= ST_INIT;
            clearCntReg   <= '0;
            readyReg      <= 1'b0;
            rdDataReg     <= 32'h0;
            rdValidReg    <= 1'b0;
            misalignReg   <= 1'b0;
            outOfRangeReg <= 1'b0;
        end else begin
            case (stateReg)
                ST_INIT: begin
                    rdValidReg    <= 1'b0;
                    misalignReg   <= 1'b0;
                    outOfRangeReg <= 1'b0;
                    clearCntReg   <= clearCntReg + 1'b1;
                    if (clearCntReg == IDX_W'(DEPTH_WORDS - 1)) begin
                        stateReg <= ST_READY;
                        readyReg <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (!(memRead | memWrite)) begin
                        rdValidReg    <= 1'b0;
                        misalignReg   <= 1'b0;
                        outOfRangeReg <= 1'b0;
                    end else if (!isLegal) begin
                        rdDataReg     <= 32'h0;
                        rdValidReg    <= memRead & ~memWrite;
                        misalignReg   <= isMisaligned;
                        outOfRangeReg <= ~inRange;
                    end else if (memWrite) begin
                        rdValidReg    <= 1'b0;
                        misalignReg   <= 1'b0;
                        outOfRangeReg <= 1'b0;
                    end else begin
                        rdDataReg     <= loadVal;
                        rdValidReg    <= 1'b1;
                        misalignReg   <= 1'b0;
                        outOfRangeReg <= 1'b0;
                    end
                end
                default: stateReg <= ST_INIT;
            endcase
        end
    end

    assign rdData     = rdDataReg;
    assign rdValid    = rdValidReg;
    assign misalign   = misalignReg;
    assign outOfRange = outOfRangeReg;
    assign ready      = readyReg;

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: clearing sequence, aligned loads/stores with
// extension, lane merging, illegal requests, read/write conflict and re-reset.
module tb_data_mem;

    logic        clk;
    logic        rst_n;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  size;
    logic        signedLd;
    logic [31:0] addr;
    logic [31:0] wrData;
    logic [31:0] rdData;
    logic        rdValid;
    logic        misalign;
    logic        outOfRange;
    logic        ready;

    int passCount  = 0;
    int checkCount = 0;

    data_mem #(.DEPTH_WORDS(64), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .memRead   (memRead),
        .memWrite  (memWrite),
        .size      (size),
        .signedLd  (signedLd),
        .addr      (addr),
        .wrData    (wrData),
        .rdData    (rdData),
        .rdValid   (rdValid),
        .misalign  (misalign),
        .outOfRange(outOfRange),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one request for one edge, then return inputs to idle; outputs are
    // sampled 1 time unit after the edge.
    task automatic doReq(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sgn, input logic [31:0] a, input logic [31:0] d);
        memRead  = rd;
        memWrite = wr;
        size     = sz;
        signedLd = sgn;
        addr     = a;
        wrData   = d;
        @(posedge clk);
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
        $display("req rd=%0b wr=%0b size=%0d sgn=%0b addr=%h data=%h -> rdData=%h rdValid=%0b mis=%0b oor=%0b ready=%0b",
                 rd, wr, sz, sgn, a, d, rdData, rdValid, misalign, outOfRange, ready);
    endtask

    // Hold a word load at addr 0 while clearing runs; ready must rise on the 64th edge.
    task automatic waitClear(input string tag);
        int bad;
        bad      = 0;
        memRead  = 1'b1;
        memWrite = 1'b0;
        size     = 2'b10;
        addr     = 32'h0;
        for (int i = 1; i <= 63; i++) begin
            @(posedge clk);
            #1;
            if (ready !== 1'b0 || rdValid !== 1'b0 || misalign !== 1'b0 || outOfRange !== 1'b0)
                bad++;
        end
        checkCount++;
        if (bad != 0) $display("FAIL %s_init_quiet: %0d bad cycles, required 0", tag, bad);
        else passCount++;
        @(posedge clk);
        #1;
        memRead = 1'b0;
        checkCount++;
        if (ready !== 1'b1 || rdValid !== 1'b0)
            $display("FAIL %s_ready_rise: ready=%b rdValid=%b, required ready=1 rdValid=0", tag, ready, rdValid);
        else passCount++;
        $display("%s clear done ready=%0b", tag, ready);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; memRead = 1'b1; memWrite = 1'b0; size = 2'b10;
        signedLd = 1'b0; addr = 32'h0; wrData = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if ({rdData, rdValid, misalign, outOfRange, ready} !== 36'h0)
            $display("FAIL reset_outputs: rdData=%h v=%b m=%b o=%b r=%b, required all 0",
                     rdData, rdValid, misalign, outOfRange, ready);
        else passCount++;
        rst_n = 1'b1;
        waitClear("reset");
        doReq(1, 0, 2'b10, 0, 32'h0, 32'h0);
        checkCount++;
        if (rdValid !== 1'b1 || rdData !== 32'h0)
            $display("FAIL first_load: rdData=%h rdValid=%b, required 00000000 1", rdData, rdValid);
        else passCount++;
    endtask

    task automatic test_extension;
        doReq(0, 1, 2'b10, 0, 32'h10, 32'h8765_4321);
        checkCount++;
        if (rdValid !== 1'b0 || misalign !== 1'b0 || outOfRange !== 1'b0)
            $display("FAIL store_flags: v=%b m=%b o=%b, required 0 0 0", rdValid, misalign, outOfRange);
        else passCount++;
        doReq(1, 0, 2'b00, 1, 32'h13, 32'h0);
        checkCount++;
        if (rdValid !== 1'b1 || rdData !== 32'hFFFF_FF87)
            $display("FAIL byte_signed: rdData=%h v=%b, required FFFFFF87 1", rdData, rdValid);
        else passCount++;
        doReq(1, 0, 2'b00, 0, 32'h13, 32'h0);
        checkCount++;
        if (rdData !== 32'h0000_0087)
            $display("FAIL byte_unsigned: rdData=%h, required 00000087", rdData);
        else passCount++;
        doReq(1, 0, 2'b01, 1, 32'h10, 32'h0);
        checkCount++;
        if (rdData !== 32'h0000_4321)
            $display("FAIL half_signed_lo: rdData=%h, required 00004321", rdData);
        else passCount++;
        doReq(1, 0, 2'b01, 1, 32'h12, 32'h0);
        checkCount++;
        if (rdData !== 32'hFFFF_8765)
            $display("FAIL half_signed_hi: rdData=%h, required FFFF8765", rdData);
        else passCount++;
    endtask

    task automatic test_byte_merge;
        doReq(0, 1, 2'b00, 0, 32'h11, 32'h1234_56AA);
        doReq(1, 0, 2'b10, 0, 32'h10, 32'h0);
        checkCount++;
        if (rdValid !== 1'b1 || rdData !== 32'h8765_AA21)
            $display("FAIL byte_merge: rdData=%h v=%b, required 8765AA21 1", rdData, rdValid);
        else passCount++;
    endtask

    task automatic test_illegal;
        doReq(1, 0, 2'b01, 0, 32'h11, 32'h0);
        checkCount++;
        if (misalign !== 1'b1 || outOfRange !== 1'b0 || rdValid !== 1'b1 || rdData !== 32'h0)
            $display("FAIL half_misalign: m=%b o=%b v=%b rdData=%h, required 1 0 1 00000000",
                     misalign, outOfRange, rdValid, rdData);
        else passCount++;
        doReq(0, 1, 2'b10, 0, 32'h102, 32'hDEAD_BEEF);
        checkCount++;
        if (misalign !== 1'b1 || outOfRange !== 1'b1 || rdValid !== 1'b0)
            $display("FAIL both_flags: m=%b o=%b v=%b, required 1 1 0", misalign, outOfRange, rdValid);
        else passCount++;
        // Idle cycle clears flags; index 0x40 must not alias onto word 0.
        @(posedge clk);
        #1;
        checkCount++;
        if (misalign !== 1'b0 || outOfRange !== 1'b0 || rdValid !== 1'b0)
            $display("FAIL idle_clear: m=%b o=%b v=%b, required 0 0 0", misalign, outOfRange, rdValid);
        else passCount++;
        doReq(1, 0, 2'b10, 0, 32'h0, 32'h0);
        checkCount++;
        if (rdData !== 32'h0)
            $display("FAIL no_alias_write: rdData=%h, required 00000000", rdData);
        else passCount++;
        doReq(1, 0, 2'b10, 0, 32'h10, 32'h0);
        checkCount++;
        if (rdData !== 32'h8765_AA21)
            $display("FAIL array_unchanged: rdData=%h, required 8765AA21", rdData);
        else passCount++;
        doReq(1, 0, 2'b10, 0, 32'h100, 32'h0);
        checkCount++;
        if (outOfRange !== 1'b1 || misalign !== 1'b0 || rdValid !== 1'b1 || rdData !== 32'h0)
            $display("FAIL oor_load: o=%b m=%b v=%b rdData=%h, required 1 0 1 00000000",
                     outOfRange, misalign, rdValid, rdData);
        else passCount++;
        doReq(1, 0, 2'b11, 0, 32'h10, 32'h0);
        checkCount++;
        if (misalign !== 1'b1 || rdData !== 32'h0)
            $display("FAIL size11: m=%b rdData=%h, required 1 00000000", misalign, rdData);
        else passCount++;
    endtask

    task automatic test_back_to_back;
        doReq(1, 1, 2'b10, 0, 32'h20, 32'd500);
        checkCount++;
        if (rdValid !== 1'b0)
            $display("FAIL rw_conflict: rdValid=%b, required 0", rdValid);
        else passCount++;
        doReq(1, 0, 2'b10, 0, 32'h20, 32'h0);
        checkCount++;
        if (rdValid !== 1'b1 || rdData !== 32'd500)
            $display("FAIL raw_next: rdData=%0d v=%b, required 500 1", rdData, rdValid);
        else passCount++;
    endtask

    task automatic test_reset_mid;
        memRead = 1'b1; memWrite = 1'b0; size = 2'b10; addr = 32'h10;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkCount++;
        if ({rdData, rdValid, misalign, outOfRange, ready} !== 36'h0)
            $display("FAIL mid_reset_outputs: rdData=%h v=%b m=%b o=%b r=%b, required all 0",
                     rdData, rdValid, misalign, outOfRange, ready);
        else passCount++;
        waitClear("mid");
        doReq(1, 0, 2'b10, 0, 32'h10, 32'h0);
        checkCount++;
        if (rdValid !== 1'b1 || rdData !== 32'h0)
            $display("FAIL cleared_after_reset: rdData=%h v=%b, required 00000000 1", rdData, rdValid);
        else passCount++;
    endtask

    initial begin
        test_reset;
        test_extension;
        test_byte_merge;
        test_illegal;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
